// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier
// Iterative radix-2 Booth multiplier. It holds one operand pair at a time and
// retires one Booth step per write_clock edge. Operands are widened by one bit
// so that signed and unsigned modes share the same datapath. The product
// register holds its value until the consumer takes it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand pair
// RUN   | one Booth step per edge, WIDTH+1 steps in total
// DONE  | out_valid high, product held until out_ready
module seq_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               write_clock,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  // Extended operand width, partial-product register width, step counter width
  localparam int EW = WIDTH + 1;
  localparam int PW = 2 * EW + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state;
  logic [EW-1:0] a_reg;
  logic [PW-1:0] p_reg;
  logic [CW-1:0] count;

  logic [EW-1:0] x_ext;
  logic [EW-1:0] y_ext;
  logic [EW-1:0] upper;
  logic [EW-1:0] upper_next;
  logic [PW-1:0] p_next;

  // Widen operands by one bit: sign bit copied in signed mode, zero otherwise
  always_comb begin
    x_ext = {is_signed & x[WIDTH-1], x};
    y_ext = {is_signed & y[WIDTH-1], y};
  end

  // One Booth step: recode P[1:0], add/subtract A in the upper field, then shift
  always_comb begin
    upper      = p_reg[PW-1 -: EW];
    upper_next = upper;
    case (p_reg[1:0])
      2'b01:   upper_next = upper + a_reg;
      2'b10:   upper_next = upper - a_reg;
      default: upper_next = upper;
    endcase
    // Arithmetic right shift of {upper_next, p_reg[EW:0]}; carry out of the
    // upper field is dropped on purpose, the widened operands cannot overflow it
    p_next = {upper_next[EW-1], upper_next, p_reg[EW:1]};
  end

  // Control FSM with registered handshake outputs and the datapath registers
  always_ff @(posedge write_clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      count     <= '0;
      a_reg     <= '0;
      p_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= x_ext;
            p_reg    <= {{EW{1'b0}}, y_ext, 1'b0};
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          p_reg <= p_next;
          if (count == LAST_STEP) begin
            // Last step: the shifted P already holds the finished product
            product   <= p_next[2*WIDTH:1];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          // in_ready is raised only after leaving DONE, so no same-edge accept
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier
// Directed tests on an 8-bit instance, randomized throttled traffic on a
// 32-bit instance. Expected products and accept times go into queues when an
// operand pair is driven; monitors pop them when the DUT produces output.
module tb_seq_booth_multiplier;

  logic write_clock = 1'b0;
  logic rst;

  logic        iv8, ir8, s8, ov8, or8, busy8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;

  logic        iv32, ir32, s32, ov32, or32, busy32;
  logic [31:0] x32, y32;
  logic [63:0] p32;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  int     or8_mode = 0;

  logic [15:0] exp8_q[$];
  longint      acc8_q[$];
  logic [63:0] exp32_q[$];
  longint      acc32_q[$];

  localparam int N32 = 1000;

  always #5 write_clock = ~write_clock;

  // Edge counter used for latency measurement
  always @(posedge write_clock) cyc <= cyc + 1;

  seq_booth_multiplier #(.WIDTH(8)) u_mul8 (
    .write_clock(write_clock), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8), .is_signed(s8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );

  seq_booth_multiplier #(.WIDTH(32)) u_mul32 (
    .write_clock(write_clock), .rst(rst),
    .in_valid(iv32), .in_ready(ir32), .x(x32), .y(y32), .is_signed(s32),
    .out_valid(ov32), .out_ready(or32), .product(p32), .busy(busy32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference product: extend to 64 bits per mode, multiply, keep low bits
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input int w);
    logic [63:0] mask, ea, eb;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    ea = a & mask;
    eb = b & mask;
    if (s && ea[w-1]) ea = ea | ~mask;
    if (s && eb[w-1]) eb = eb | ~mask;
    return ea * eb;
  endfunction

  // Garbage on the 8-bit inputs while the DUT is not ready; in_valid low once it is
  task automatic junk8();
    if (ir8) iv8 = 1'b0;
    else iv8 = 1'($urandom_range(0, 1));
    x8 = 8'($urandom);
    y8 = 8'($urandom);
    s8 = 1'($urandom_range(0, 1));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp);
    for (int n = 0; n < 200; n++) begin
      @(negedge write_clock);
      if (ir8) break;
      junk8();
    end
    check("ir8_wait", ir8, 1);
    if (ir8) begin
      x8 = a; y8 = b; s8 = s; iv8 = 1'b1;
      exp8_q.push_back(exp);
      acc8_q.push_back(cyc + 1);
      @(negedge write_clock);
      iv8 = 1'b0;
      x8 = 8'($urandom);
      y8 = 8'($urandom);
    end
  endtask

  task automatic drain8();
    for (int n = 0; n < 300; n++) begin
      if (exp8_q.size() == 0) break;
      @(negedge write_clock);
    end
    check("drain8", exp8_q.size(), 0);
  endtask

  // 8-bit monitor: drives out_ready per mode, checks latency and product
  initial begin : mon8
    logic prev;
    prev = 1'b0;
    or8 = 1'b1;
    forever begin
      @(negedge write_clock);
      case (or8_mode)
        0:       or8 = 1'b1;
        1:       or8 = 1'b0;
        default: or8 = 1'($urandom_range(0, 1));
      endcase
      if (rst) prev = 1'b0;
      else begin
        if (ov8 && !prev) begin
          check("lat8_pending", acc8_q.size() != 0, 1);
          if (acc8_q.size() != 0) check("lat8", cyc - acc8_q.pop_front(), 9);
        end
        prev = ov8;
        if (ov8 && or8) begin
          check("prod8_pending", exp8_q.size() != 0, 1);
          if (exp8_q.size() != 0) check("prod8", p8, exp8_q.pop_front());
        end
      end
    end
  end

  // 32-bit monitor: random out_ready throttling
  initial begin : mon32
    logic prev;
    prev = 1'b0;
    or32 = 1'b1;
    forever begin
      @(negedge write_clock);
      or32 = 1'($urandom_range(0, 1));
      if (rst) prev = 1'b0;
      else begin
        if (ov32 && !prev) begin
          check("lat32_pending", acc32_q.size() != 0, 1);
          if (acc32_q.size() != 0) check("lat32", cyc - acc32_q.pop_front(), 33);
        end
        prev = ov32;
        if (ov32 && or32) begin
          check("prod32_pending", exp32_q.size() != 0, 1);
          if (exp32_q.size() != 0) check("prod32", p32, exp32_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int issued;
    longint start;
    logic [31:0] cx[4];
    logic [31:0] cy[4];
    logic        cs[4];

    rst = 1'b1;
    iv8 = 1'b0; x8 = '0; y8 = '0; s8 = 1'b0;
    iv32 = 1'b0; x32 = '0; y32 = '0; s32 = 1'b0;
    repeat (3) @(negedge write_clock);

    check("rst_ir8", ir8, 1);
    check("rst_ov8", ov8, 0);
    check("rst_p8", p8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_ir32", ir32, 1);
    check("rst_ov32", ov32, 0);
    check("rst_p32", p32, 0);
    check("rst_busy32", busy32, 0);
    rst = 1'b0;
    @(negedge write_clock);

    // Signed small operands, then product retention after release
    op8(8'hFD, 8'h05, 1'b1, 16'hFFF1);
    drain8();
    repeat (2) @(negedge write_clock);
    check("hold_p8_idle", p8, 16'hFFF1);
    check("idle_ir8", ir8, 1);
    check("idle_ov8", ov8, 0);
    check("idle_busy8", busy8, 0);

    // Same bits, both modes; extreme values
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    op8(8'hFF, 8'hFF, 1'b1, 16'h0001);
    op8(8'h80, 8'h80, 1'b1, 16'h4000);
    op8(8'h80, 8'h7F, 1'b1, 16'hC080);
    op8(8'h80, 8'h7F, 1'b0, 16'h3F80);
    drain8();

    // Backpressure: out_ready low for 20 edges, inputs toggled during RUN and DONE
    or8_mode = 1;
    op8(8'h13, 8'h07, 1'b0, 16'h0085);
    for (int n = 0; n < 40; n++) begin
      if (ov8) break;
      junk8();
      @(negedge write_clock);
    end
    check("ov8_rise", ov8, 1);
    repeat (20) begin
      @(negedge write_clock);
      junk8();
      check("stall_ov8", ov8, 1);
      check("stall_p8", p8, 16'h0085);
      check("stall_ir8", ir8, 0);
    end
    iv8 = 1'b0;
    or8_mode = 0;
    drain8();

    // Reset in the middle of RUN drops the operation
    op8(8'h7B, 8'h2D, 1'b1, 16'h159F);
    check("busy8_run", busy8, 1);
    repeat (3) @(negedge write_clock);
    rst = 1'b1;
    #1;
    check("midrst_ov8", ov8, 0);
    check("midrst_ir8", ir8, 1);
    check("midrst_p8", p8, 0);
    check("midrst_busy8", busy8, 0);
    exp8_q.delete();
    acc8_q.delete();
    @(negedge write_clock);
    rst = 1'b0;
    op8(8'h7B, 8'h2D, 1'b1, 16'h159F);
    op8(8'h85, 8'h2D, 1'b0, 16'h1761);
    op8(8'h85, 8'h2D, 1'b1, 16'hEA61);
    drain8();

    // 32-bit randomized traffic, unsigned half then signed half, corners first
    cx = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    cy = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    cs = '{1'b1, 1'b0, 1'b1, 1'b0};
    issued = 0;
    start = cyc;
    while (issued < N32 && (cyc - start) < 70000) begin
      @(negedge write_clock);
      if (ir32) begin
        if (issued < 4) begin
          x32 = cx[issued]; y32 = cy[issued]; s32 = cs[issued];
        end else begin
          x32 = $urandom; y32 = $urandom; s32 = (issued >= N32 / 2);
        end
        iv32 = 1'b1;
        exp32_q.push_back(ref_mul({32'd0, x32}, {32'd0, y32}, s32, 32));
        acc32_q.push_back(cyc + 1);
        issued++;
      end else begin
        iv32 = 1'($urandom_range(0, 1));
        x32 = $urandom;
        y32 = $urandom;
        s32 = 1'($urandom_range(0, 1));
      end
    end
    @(negedge write_clock);
    iv32 = 1'b0;
    check("issued32", issued, N32);
    for (int n = 0; n < 500; n++) begin
      if (exp32_q.size() == 0) break;
      @(negedge write_clock);
    end
    check("drain32", exp32_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
